alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of an external 4-bit combinational ALU, with an in-order result register.
// Optional operand chaining (previous result replaces operand a) is enabled by defining ALU_CHAIN_EN.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [1:0]               in_op,
`ifdef ALU_CHAIN_EN
  input  logic                     in_chain,
`endif
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [1:0]               alu_op,
  input  logic [W-1:0]             alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [1:0]               out_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_a  [DEPTH];
  logic [W-1:0]  mem_b  [DEPTH];
  logic [1:0]    mem_op [DEPTH];
`ifdef ALU_CHAIN_EN
  logic          mem_chain [DEPTH];
  logic [W-1:0]  last_result_reg;
`endif

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic          out_valid_reg;
  logic [W-1:0]  out_result_reg;
  logic          out_carry_reg;
  logic          out_zero_reg;
  logic [1:0]    out_op_reg;

  logic          not_empty;
  logic          push;
  logic          cap;

  assign not_empty = (count_reg != '0);
  assign in_ready  = (count_reg < FULL) && !rst;
  assign push      = in_valid && in_ready;
  assign cap       = not_empty && (!out_valid_reg || out_ready);

  // Storage needs no reset: the pointers and count alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg]  <= in_a;
      mem_b[wr_ptr_reg]  <= in_b;
      mem_op[wr_ptr_reg] <= in_op;
`ifdef ALU_CHAIN_EN
      mem_chain[wr_ptr_reg] <= in_chain;
`endif
    end
  end

  // The head is presented combinationally so the ALU result is ready for the capture edge.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (not_empty) begin
      alu_a  = mem_a[rd_ptr_reg];
      alu_b  = mem_b[rd_ptr_reg];
      alu_op = mem_op[rd_ptr_reg];
`ifdef ALU_CHAIN_EN
      if (mem_chain[rd_ptr_reg]) begin
        alu_a = last_result_reg;
      end
`endif
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, cap})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_carry_reg  <= 1'b0;
      out_zero_reg   <= 1'b0;
      out_op_reg     <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (cap) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        out_valid_reg  <= 1'b1;
        out_result_reg <= alu_result;
        out_carry_reg  <= alu_carry;
        out_zero_reg   <= alu_zero;
        out_op_reg     <= mem_op[rd_ptr_reg];
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg  <= 1'b0;
      end
    end
  end

`ifdef ALU_CHAIN_EN
  // Survives draining so the next chained command always sees the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_result_reg <= '0;
    end else if (cap) begin
      last_result_reg <= alu_result;
    end
  end
`endif

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_carry  = out_carry_reg;
  assign out_zero   = out_zero_reg;
  assign out_op     = out_op_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed table, hand sequences and a queue-based reference model.
// Define ALU_CHAIN_EN on both bench and design to exercise the chaining build.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic [1:0]    in_op;
  logic          in_chain;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [1:0]    alu_op;
  logic [3:0]    alu_result;
  logic          alu_carry;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_result;
  logic          out_carry;
  logic          out_zero;
  logic [1:0]    out_op;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic       carry;
    logic       zero;
  } alu_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       chain;
  } cmd_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       carry;
    logic       zero;
  } vec_t;

  // Behaviour of the 4-bit ALU: add carry-out, subtract borrow, logic ops clear carry.
  function automatic alu_t alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    alu_t r;
    int   s;
    r = '0;
    case (op)
      2'b00: begin
        s = int'(a) + int'(b);
        r.res   = 4'(s % 16);
        r.carry = (s > 15);
      end
      2'b01: begin
        s = int'(a) - int'(b);
        r.res   = 4'((s + 16) % 16);
        r.carry = (s < 0);
      end
      2'b10:   r.res = a & b;
      default: r.res = a ^ b;
    endcase
    r.zero = (r.res == 4'd0);
    return r;
  endfunction

  assign {alu_result, alu_carry, alu_zero} = alu_f(alu_a, alu_b, alu_op);

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
`ifdef ALU_CHAIN_EN
    .in_chain   (in_chain),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_op     (out_op),
    .count      (count)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: pending commands, output register, last captured result.
  cmd_t       q[$];
  alu_t       obs[$];
  logic       mv;
  alu_t       mout;
  logic [1:0] mop;
  logic [3:0] mlast;
  logic       acc;
  logic       mcap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    cmd_t       h;
    logic [3:0] ea;
    @(posedge clk);
    cyc++;
    acc  = 1'b0;
    mcap = 1'b0;
    if (rst) begin
      q.delete();
      mv    = 1'b0;
      mout  = '0;
      mop   = '0;
      mlast = '0;
    end else begin
      mcap = (q.size() > 0) && (!mv || out_ready);
      acc  = in_valid && (q.size() < DEPTH);
      if (mcap) begin
        h     = q.pop_front();
        mout  = alu_f((CHAIN && h.chain) ? mlast : h.a, h.b, h.op);
        mop   = h.op;
        mv    = 1'b1;
        mlast = mout.res;
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      if (acc) q.push_back('{in_a, in_b, in_op, in_chain});
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(mv));
    if (mv) begin
      chk("out_result", 32'(out_result), 32'(mout.res));
      chk("out_carry", 32'(out_carry), 32'(mout.carry));
      chk("out_zero", 32'(out_zero), 32'(mout.zero));
      chk("out_op", 32'(out_op), 32'(mop));
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(!rst && (q.size() < DEPTH)));
    if (q.size() > 0) begin
      ea = (CHAIN && q[0].chain) ? mlast : q[0].a;
      chk("alu_a", 32'(alu_a), 32'(ea));
      chk("alu_b", 32'(alu_b), 32'(q[0].b));
      chk("alu_op", 32'(alu_op), 32'(q[0].op));
    end else begin
      chk("alu_idle", 32'({alu_a, alu_b, alu_op}), 32'(0));
    end
    if (mcap) obs.push_back({out_result, out_carry, out_zero});
  endtask

  // Leaves in_valid high after acceptance so back-to-back calls push on consecutive edges.
  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic ch);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_chain = ch;
    n = 0;
    step();
    while (!acc && n < 20) begin
      n++;
      step();
    end
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout cycle %0d: got no acceptance expected acceptance within 20 cycles", cyc);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'h3, 4'h5, 2'b00, 4'h8, 1'b0, 1'b0};
    vecs[1] = '{4'hF, 4'h1, 2'b00, 4'h0, 1'b1, 1'b1};
    vecs[2] = '{4'h2, 4'h3, 2'b01, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'h9, 4'h4, 2'b01, 4'h5, 1'b0, 1'b0};
    vecs[4] = '{4'h6, 4'h3, 2'b10, 4'h2, 1'b0, 1'b0};
    vecs[5] = '{4'h5, 4'h5, 2'b11, 4'h0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0; out_ready = 1'b0;
    mv = 1'b0; mout = '0; mop = '0; mlast = '0; acc = 1'b0; mcap = 1'b0;
    repeat (2) step();

    // Reset release with no traffic
    @(negedge clk) rst = 1'b0;
    step();
    chk("idle_out_valid", 32'(out_valid), 32'(0));
    chk("idle_count", 32'(count), 32'(0));
    chk("idle_in_ready", 32'(in_ready), 32'(1));
    chk("idle_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
    chk("idle_out_regs", 32'({out_result, out_carry, out_zero, out_op}), 32'(0));

    // Directed single commands
    @(negedge clk) out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      obs.delete();
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0);
      idle();
      step();
      chk("vec_caps", 32'(obs.size()), 32'(1));
      chk("vec_result", 32'(out_result), 32'(vecs[i].res));
      chk("vec_carry", 32'(out_carry), 32'(vecs[i].carry));
      chk("vec_zero", 32'(out_zero), 32'(vecs[i].zero));
      chk("vec_op", 32'(out_op), 32'(vecs[i].op));
      $display("vec %0d: a=%0h b=%0h op=%0d -> result=%0h carry=%0b zero=%0b", i, vecs[i].a, vecs[i].b,
               vecs[i].op, out_result, out_carry, out_zero);
    end
    repeat (2) step();

    // Fill under backpressure, then drain
    @(negedge clk) out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(i), 4'(15 - i), 2'b10, 1'b0);
    idle();
    step();
    chk("full_count", 32'(count), 32'(4));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    repeat (3) step();
    chk("stall_valid", 32'(out_valid), 32'(1));
    chk("stall_result", 32'({out_result, out_op}), 32'({4'h0, 2'b10}));
    obs.delete();
    @(negedge clk) out_ready = 1'b1;
    repeat (5) step();
    chk("drain_caps", 32'(obs.size()), 32'(4));
    for (int i = 0; i < obs.size(); i++) chk("drain_result", 32'(obs[i].res), 32'(0));
    chk("drain_count", 32'(count), 32'(0));
    chk("drain_valid", 32'(out_valid), 32'(0));
    $display("fill/drain: %0d results drained, count=%0d", obs.size(), count);

    // Continuous stream keeps occupancy at one
    obs.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 4'($urandom); in_b = 4'($urandom);
      in_op = 2'($urandom); in_chain = 1'($urandom);
      step();
      chk("stream_count", 32'(count), 32'(1));
    end
    idle();
    repeat (3) step();
    chk("stream_caps", 32'(obs.size()), 32'(40));
    $display("stream: %0d results", obs.size());

    // Reset with work in flight
    @(negedge clk) out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'(i + 1), 4'h2, 2'b00, 1'b0);
    idle();
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_count", 32'(count), 32'(3));
    @(negedge clk) rst = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_out_regs", 32'({out_result, out_carry, out_zero, out_op}), 32'(0));
    obs.delete();
    @(negedge clk) begin rst = 1'b0; out_ready = 1'b1; end
    repeat (5) step();
    chk("rst_no_stale", 32'(obs.size()), 32'(0));
    $display("reset in flight: count=%0d out_valid=%0b", count, out_valid);

    // Chained pair
    obs.delete();
    push_cmd(4'h7, 4'h1, 2'b00, 1'b0);
    push_cmd(4'h0, 4'h3, 2'b01, 1'b1);
    idle();
    repeat (2) step();
    chk("chain_caps", 32'(obs.size()), 32'(2));
    if (obs.size() == 2) begin
      chk("chain_res0", 32'(obs[0].res), 32'(8));
      chk("chain_res1", 32'(obs[1].res), CHAIN ? 32'(5) : 32'(13));
      chk("chain_carry1", 32'(obs[1].carry), CHAIN ? 32'(0) : 32'(1));
      chk("chain_zero1", 32'(obs[1].zero), 32'(0));
      $display("chain: results %0h then %0h carry=%0b", obs[0].res, obs[1].res, obs[1].carry);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      in_a = 4'($urandom); in_b = 4'($urandom); in_op = 2'($urandom); in_chain = 1'($urandom);
      step();
    end
    idle();
    @(negedge clk) out_ready = 1'b1;
    repeat (DEPTH + 3) step();
    chk("final_count", 32'(count), 32'(0));
    chk("final_valid", 32'(out_valid), 32'(0));
    $display("random: done at cycle %0d", cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
